// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: the FSM state encoding
// and the parity-mode selector values.
package uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_fifo.sv
// Generic FIFO with first-word-fall-through head; a push while full or a pop while
// empty is ignored. Full/empty are told apart by an extra pointer wrap bit.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter: start bit, DATA_W payload bits LSB first, optional parity,
// STOP_BITS stop bits; frames run back-to-back while the buffer holds data and enable=1.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  output logic              ready,
  output logic              out,
  output logic              done,
  output logic              busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY == PAR_ODD);

  logic [2:0]        state, state_n;
  logic [CW-1:0]     baud, baud_n;
  logic [3:0]        bit_cnt, bit_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              par_bit, par_n;
  logic              out_n;

  logic              full, empty;
  logic [DATA_W-1:0] head;
  logic              push, pop;
  logic              bit_end, last_stop;

  assign push      = start && enable && !full;
  assign ready     = !full;
  assign bit_end   = (baud == BAUD_LAST);
  assign last_stop = (state == ST_STOP) && bit_end && (bit_cnt == STOP_LAST);
  assign pop       = !empty && enable && ((state == ST_IDLE) || last_stop);
  assign done      = last_stop;
  assign busy      = (state != ST_IDLE);

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .data_in (data_in),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  always_comb begin
    state_n = state;
    baud_n  = baud + CW'(1);
    bit_n   = bit_cnt;
    shift_n = shift;
    par_n   = par_bit;
    case (state)
      ST_IDLE: baud_n = '0;
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          baud_n  = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_n   = '0;
            state_n = ST_IDLE;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase

    // A pop from IDLE or the last stop cycle overrides the plain transition above.
    if (pop) begin
      state_n = ST_START;
      baud_n  = '0;
      bit_n   = '0;
      shift_n = head;
      par_n   = (^head) ^ PAR_INV;
    end

    // The line register tracks the upcoming state so it changes on the bit boundary.
    case (state_n)
      ST_START: out_n = 1'b0;
      ST_DATA:  out_n = shift_n[0];
      ST_PAR:   out_n = par_n;
      default:  out_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      out     <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      par_bit <= par_n;
      out     <= out_n;
    end
  end

endmodule
